jump_target_encoder: RTL and testbench

// - Inverse of the jump-address generator: turns a 32-bit jump target plus the current PC+4 into a
//   J-type instruction word {opcode, instr_index[25:0]}. Used by the self-test/boot-ROM path and by
//   the verification environment to build J/JAL words.
// - Checks that the target is encodable, and queues results in a 2-entry output buffer with

---
 rtl/mips_pkg.sv | 24 ++
 rtl/jte_fifo2.sv | 56 +++++
 rtl/jump_target_encoder.sv | 86 ++++++++
 tb/tb_jump_target_encoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants used by the jump-target encoder and its buffer.
// Holds J-type field positions, opcodes, error-flag indices and the buffer occupancy type.
package mips_pkg;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int IDX_MSB = 25;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_REGION   = 1;

    // Buffer entry is {err[1:0], instr[31:0]}.
    localparam int ENTRY_W = 34;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/jte_fifo2.sv
// Two-entry in-order buffer for encoded jump words; head entry is always at out_data.
// The occupancy FSM is exported on state so the top can derive its handshake flags from it.
module jte_fifo2
    import mips_pkg::*;
#(
    parameter int W = ENTRY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] in_data,
    input  logic         pop,
    output logic [W-1:0] out_data,
    output occ_state_t   state
);

    logic [W-1:0] tail;

    // A push in FULL or a pop in EMPTY cannot be a real handshake, so both are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OCC_EMPTY;
            out_data <= '0;
            tail     <= '0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        out_data <= in_data;
                        state    <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && !pop) begin
                        tail  <= in_data;
                        state <= OCC_FULL;
                    end else if (!push && pop) begin
                        state <= OCC_EMPTY;
                    end else if (push && pop) begin
                        out_data <= in_data;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        out_data <= tail;
                        state    <= OCC_ONE;
                    end
                end
                default: begin
                    state <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/jump_target_encoder.sv
// Builds J/JAL instruction words from a target address and PC+4, flags unencodable targets,
// buffers results two deep and keeps saturating good/bad word counters.
module jump_target_encoder #(
    parameter logic [5:0] OP_J   = mips_pkg::OP_J,
    parameter logic [5:0] OP_JAL = mips_pkg::OP_JAL,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc4,
    input  logic [31:0]      in_target,
    input  logic             in_link,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [1:0]       out_err,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);

    import mips_pkg::ENTRY_W;
    import mips_pkg::OPC_MSB;
    import mips_pkg::OPC_LSB;
    import mips_pkg::IDX_MSB;
    import mips_pkg::ERR_MISALIGN;
    import mips_pkg::ERR_REGION;
    import mips_pkg::occ_state_t;
    import mips_pkg::OCC_EMPTY;
    import mips_pkg::OCC_FULL;

    // Handshakes: a transfer happens on a posedge where valid & ready are both high.
    // Ready is a function of buffer occupancy only, never of the opposite side's valid.
    logic         accept;
    logic         pop;
    logic [1:0]   err;
    logic [31:0]  instr;
    logic [ENTRY_W-1:0] head;
    occ_state_t   fifo_state;

    assign in_ready  = (fifo_state != OCC_FULL);
    assign out_valid = (fifo_state != OCC_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        err               = 2'b00;
        err[ERR_MISALIGN] = |in_target[1:0];
        err[ERR_REGION]   = (in_target[31:28] != in_pc4[31:28]);
        instr             = 32'h0000_0000;
        if (err == 2'b00) begin
            instr[OPC_MSB:OPC_LSB] = in_link ? OP_JAL : OP_J;
            instr[IDX_MSB:0]       = in_target[27:2];
        end
    end

    jte_fifo2 #(
        .W(ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .in_data  ({err, instr}),
        .pop      (pop),
        .out_data (head),
        .state    (fifo_state)
    );

    assign out_err   = head[ENTRY_W-1:32];
    assign out_instr = head[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ok  <= '0;
            cnt_err <= '0;
        end else if (accept) begin
            if (err == 2'b00) begin
                if (cnt_ok != {CNT_W{1'b1}}) cnt_ok <= cnt_ok + 1'b1;
            end else begin
                if (cnt_err != {CNT_W{1'b1}}) cnt_err <= cnt_err + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jump_target_encoder.sv
// Scoreboard bench for jump_target_encoder: driver pushes expected words, a negedge monitor
// pops and compares every delivered word; directed checks cover counters, backpressure and reset.
module tb_jump_target_encoder;
    import mips_pkg::*;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc4;
    logic [31:0]      in_target;
    logic             in_link;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [1:0]       out_err;
    logic [CNT_W-1:0] cnt_ok;
    logic [CNT_W-1:0] cnt_err;

    logic [33:0] exp_q[$];
    int tests  = 0;
    int failed = 0;
    int pops   = 0;
    int cyc    = 0;
    int bad_occ = 0;
    bit stream_on = 0;

    jump_target_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc4    (in_pc4),
        .in_target (in_target),
        .in_link   (in_link),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .cnt_ok    (cnt_ok),
        .cnt_err   (cnt_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        exp_q.delete();
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // driver: holds the request until accepted; records the expected word at the accept edge
    task automatic send(input logic [31:0] pc4, input logic [31:0] tgt, input logic link,
                        input logic [1:0] e, input logic [31:0] ins);
        bit acc = 0;
        int budget = 0;
        in_pc4    = pc4;
        in_target = tgt;
        in_link   = link;
        in_valid  = 1'b1;
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            budget++;
        end
        if (acc) exp_q.push_back({e, ins});
        else check("send_timeout", 34'd0, 34'd1);
        #1 in_valid = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {out_err, out_instr}, 34'h3_FFFF_FFFF);
            end else begin
                check("out_word", {out_err, out_instr}, exp_q.pop_front());
                pops++;
            end
        end
        if (stream_on && dut.u_fifo.state != OCC_ONE) bad_occ++;
    end

    initial begin
        int p0;
        int c0;
        bit drained;
        in_valid = 0; in_pc4 = '0; in_target = '0; in_link = 0; out_ready = 1'b0;
        do_reset(3);

        // reset state
        check("rst_out_valid", {33'd0, out_valid}, 34'd0);
        check("rst_in_ready", {33'd0, in_ready}, 34'd1);
        check("rst_out_word", {out_err, out_instr}, 34'd0);
        check("rst_cnt_ok", {18'd0, cnt_ok}, 34'd0);
        check("rst_cnt_err", {18'd0, cnt_err}, 34'd0);

        // basic J: visible the cycle after accept
        out_ready = 1'b1;
        send(32'h0040_0004, 32'h0040_0100, 1'b0, 2'b00, 32'h0810_0040);
        check("j_cnt_ok", {18'd0, cnt_ok}, 34'd1);
        @(negedge clk);
        check("j_out_valid_n1", {33'd0, out_valid}, 34'd1);
        @(posedge clk); #1;

        send(32'h0040_0004, 32'h004F_FFFC, 1'b1, 2'b00, 32'h0C13_FFFF);
        send(32'h0040_0004, 32'h0040_0102, 1'b0, 2'b01, 32'h0000_0000);
        send(32'h1000_0000, 32'h2000_0002, 1'b1, 2'b11, 32'h0000_0000);
        check("err_cnt_err", {18'd0, cnt_err}, 34'd2);
        send(32'h0040_0004, 32'h1000_0000, 1'b0, 2'b10, 32'h0000_0000);
        check("mix_cnt_ok", {18'd0, cnt_ok}, 34'd2);
        check("mix_cnt_err", {18'd0, cnt_err}, 34'd3);
        repeat (3) @(posedge clk);
        #1;

        // backpressure: third request held until the consumer drains
        out_ready = 1'b0;
        p0 = pops;
        send(32'h0040_0004, 32'h0040_0010, 1'b0, 2'b00, 32'h0810_0004);
        send(32'h0040_0004, 32'h0040_0020, 1'b1, 2'b00, 32'h0C10_0008);
        fork
            send(32'h0040_0004, 32'h0040_0030, 1'b0, 2'b00, 32'h0810_000C);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", {33'd0, in_ready}, 34'd0);
                    check("bp_head_stable", {out_err, out_instr}, {2'b00, 32'h0810_0004});
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drained = 0;
        for (int i = 0; i < 20 && !drained; i++) begin
            @(posedge clk);
            drained = (exp_q.size() == 0) && !out_valid;
        end
        #1;
        check("bp_drained", {33'd0, drained}, 34'd1);
        check("bp_pop_count", 34'(pops - p0), 34'd3);

        // continuous stream: one word per cycle, occupancy stays ONE
        do_reset(1);
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 100; i++) begin
            send(32'h0040_0004, 32'h0040_0000 + 32'(i * 4), 1'b0, 2'b00, 32'h0810_0000 + 32'(i));
            if (i == 0) stream_on = 1'b1;
        end
        stream_on = 1'b0;
        check("stream_cycles", 34'(cyc - c0), 34'd100);
        check("stream_occ_one", 34'(bad_occ), 34'd0);
        check("stream_cnt_ok", {18'd0, cnt_ok}, 34'd100);
        repeat (2) @(posedge clk);
        #1;

        // reset while FULL, with a request offered during the reset cycle
        out_ready = 1'b0;
        send(32'h0040_0004, 32'h0040_0100, 1'b0, 2'b00, 32'h0810_0040);
        send(32'h0040_0004, 32'h0040_0104, 1'b0, 2'b00, 32'h0810_0041);
        check("full_in_ready", {33'd0, in_ready}, 34'd0);
        in_valid = 1'b1;
        do_reset(1);
        in_valid = 1'b0;
        check("rr_out_valid", {33'd0, out_valid}, 34'd0);
        check("rr_in_ready", {33'd0, in_ready}, 34'd1);
        check("rr_out_word", {out_err, out_instr}, 34'd0);
        check("rr_cnt_ok", {18'd0, cnt_ok}, 34'd0);
        check("rr_cnt_err", {18'd0, cnt_err}, 34'd0);

        // saturation: 2^CNT_W + 3 good words
        out_ready = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 3; i++)
            send(32'h0040_0004, 32'h0040_0100, 1'b0, 2'b00, 32'h0810_0040);
        check("sat_cnt_ok", {18'd0, cnt_ok}, {18'd0, 16'hFFFF});
        check("sat_cnt_err", {18'd0, cnt_err}, 34'd0);
        send(32'h0040_0004, 32'h0040_0101, 1'b0, 2'b01, 32'h0000_0000);
        check("sat_hold_ok", {18'd0, cnt_ok}, {18'd0, 16'hFFFF});
        check("sat_err_inc", {18'd0, cnt_err}, 34'd1);

        repeat (4) @(posedge clk);
        #1;
        check("final_queue_empty", 34'(exp_q.size()), 34'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
